datapath_struct_29: RTL and testbench
=====================================

# datapath_struct_29

Register-transfer datapath that sits directly downstream of the 3-bit state controller (`controller_struct_29`). It decodes the controller's state code and performs one micro-operation per clock on a W-bit accumulator A. It returns the status flags E and F that the controller branches on. It also latches a result, counts completed passes and pulses `done` to the consumer.

## Interface

Parameters:
- `W`, 4: width of accumulator A, result R and load data `din` (W ≥ 2).
- `CW`, 8: width of the pass counter.

Ports:
- `clock`: input, 1. Single system clock; all state changes on its rising edge.
- `reset`: input, 1. Asynchronous, active-low (0 = reset). Asserts immediately; deasserts synchronously relative to the next `clock` edge.
- `state`: input, 3. Controller state code {d2,d1,d0}; S0 = 000 … S7 = 111.
- `din`: input, W. Load value for A.
- `E`: output, 1. Zero flag, combinational: E = (A == 0).
- `F`: output, 1. Sign/MSB flag, combinational: F = A[W-1].
- `A`: output, W. Accumulator register.
- `R`: output, W. Result register.
- `C`: output, 1. Sticky carry-out flag.
- `done`: output, 1. Registered one-cycle pulse.
- `passes`: output, CW. Saturating count of results latched.

## Operation

- Micro-operations are decoded from the `state` value sampled at each rising edge of `clock`:
  - S0: hold A, C, R.
  - S1: A ← `din`; C ← 0.
  - S2: A ← A + 1 mod 2^W. If A was all-ones, C ← 1; otherwise C holds.
  - S3: A ← A >> 1, logical shift; 0 enters the MSB.
  - S4: A ← A + 1, with the same C rule as S2.
  - S5: R ← A; A holds.
  - S6: A ← A − 1 mod 2^W. No borrow flag; C holds.
  - S7: R ← A; A holds.
- `done` goes to 1 for exactly one cycle following every cycle spent in S5 or S7. Two consecutive S5/S7 cycles give two consecutive `done` cycles.
- `passes` increments by 1 on every S5/S7 cycle and saturates at 2^CW − 1; it never wraps.
- E and F are pure functions of A. The controller sees the updated flags in the cycle after the operation, which is the same cycle the controller enters its next state.
- All 8 state codes are legal; there is no error state.
- Reset values while `reset` = 0:
  - A = 0, R = 0, C = 0, `done` = 0, `passes` = 0.
  - Hence E = 1 and F = 0.
- Reset asserted mid-operation: all registers clear immediately, regardless of `state` and without waiting for a clock edge. The first operation after release executes on the first rising edge at which `reset` = 1.

## Timing

- Latency from the `state` edge to the A update: 1 clock. E and F follow A combinationally within the same cycle.
- R, `passes` and `done` update on the same edge as the S5/S7 sample. `done` is high during the cycle after that S5/S7 sample.
- No stalls or back-pressure. Exactly one micro-operation per clock.
- Simultaneous events:
  - S1 loading all-ones followed by S2: A = 0, C = 1, E = 1.
  - A subsequent S1 clears C in the same edge that loads A.
  - `passes` at saturation with S5: R updates and `done` pulses; `passes` stays at the maximum.
- `din` is sampled only on S1 edges. Its value in other states is ignored, including X.

## Test plan

- Async reset: run S1 with `din` = 4'hA, then drop `reset` between edges. A = 0, R = 0, C = 0, `done` = 0, `passes` = 0, E = 1, F = 0, all before the next clock edge.
- Increment wrap: S1 with `din` = 4'hF, then S2. A = 0, C = 1, E = 1, F = 0. Then S1 with `din` = 4'h3: A = 3, C = 0.
- Shift and flags: S1 with `din` = 4'b1001 gives F = 1, E = 0. Then S3: A = 4'b0100, F = 0, E = 0. Then S4: A = 4'b0101.
- Decrement and result: S1 with `din` = 0, then S6. A = 4'hF, F = 1, C unchanged. Then S7: R = 4'hF and `done` = 1 for exactly one cycle, then 0 in S0. `passes` = 1.
- Controller-path replay: drive S0, S1, S2, S4, S5, S0 with `din` = 4'h6. A goes 6 → 7 → 8, F = 1 after S4, R = 8, single `done` pulse.
- Saturation: drive 300 consecutive S5 cycles. `passes` = 255 and `done` stays high throughout, dropping one cycle after the last S5.

Source files
------------

// File: rtl/datapath_struct_29.sv
`default_nettype none
// ============================================================================
// Module      : datapath_struct_29
// Description : Register-transfer datapath driven by a 3-bit controller state
//               code. Performs one micro-operation per clock on accumulator A,
//               returns zero/MSB flags, latches results into R, counts passes
//               (saturating) and pulses done after each result latch.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_struct_29 #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    state,
  input  logic [W-1:0]  din,
  output logic          E,
  output logic          F,
  output logic [W-1:0]  A,
  output logic [W-1:0]  R,
  output logic          C,
  output logic          done,
  output logic [CW-1:0] passes
);

  // Controller state codes and the micro-operation each one selects
  localparam logic [2:0] c_ST_HOLD   = 3'd0;
  localparam logic [2:0] c_ST_LOAD   = 3'd1;
  localparam logic [2:0] c_ST_INC_A  = 3'd2;
  localparam logic [2:0] c_ST_SHR    = 3'd3;
  localparam logic [2:0] c_ST_INC_B  = 3'd4;
  localparam logic [2:0] c_ST_LATCH_A = 3'd5;
  localparam logic [2:0] c_ST_DEC    = 3'd6;
  localparam logic [2:0] c_ST_LATCH_B = 3'd7;

  localparam logic [W-1:0]  c_ONE_W  = W'(1);
  localparam logic [CW-1:0] c_ONE_CW = CW'(1);
  localparam logic [CW-1:0] c_MAX_CW = {CW{1'b1}};

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  r_q, r_d;
  logic          c_q, c_d;
  logic          done_q, done_d;
  logic [CW-1:0] passes_q, passes_d;

  // Decode the sampled state code into next values for every register
  always_comb begin
    a_d      = a_q;
    r_d      = r_q;
    c_d      = c_q;
    done_d   = 1'b0;
    passes_d = passes_q;
    case (state)
      c_ST_LOAD: begin
        a_d = din;
        c_d = 1'b0;
      end
      c_ST_INC_A, c_ST_INC_B: begin
        a_d = a_q + c_ONE_W;
        // Carry is sticky: set on wrap from all-ones, otherwise untouched
        if (&a_q) begin
          c_d = 1'b1;
        end
      end
      c_ST_SHR: begin
        a_d = a_q >> 1;
      end
      c_ST_DEC: begin
        a_d = a_q - c_ONE_W;
      end
      c_ST_LATCH_A, c_ST_LATCH_B: begin
        r_d    = a_q;
        done_d = 1'b1;
        // Count saturates rather than wrapping
        if (passes_q != c_MAX_CW) begin
          passes_d = passes_q + c_ONE_CW;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      r_q      <= '0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
      passes_q <= '0;
    end else begin
      a_q      <= a_d;
      r_q      <= r_d;
      c_q      <= c_d;
      done_q   <= done_d;
      passes_q <= passes_d;
    end
  end

  assign A      = a_q;
  assign R      = r_q;
  assign C      = c_q;
  assign done   = done_q;
  assign passes = passes_q;
  assign E      = (a_q == '0);
  assign F      = a_q[W-1];

endmodule
`default_nettype wire

// File: tb/tb_datapath_struct_29.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_struct_29
// Description : Self-checking bench for datapath_struct_29. Directed scenarios
//               followed by random state/din sequences with occasional async
//               resets, compared against a behavioural integer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_struct_29;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int PMAX = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic [2:0]    state;
  logic [W-1:0]  din;
  logic          E, F, C, done;
  logic [W-1:0]  A, R;
  logic [CW-1:0] passes;

  int tests_run;
  int tests_failed;

  // Reference model state
  int m_a, m_r, m_c, m_done, m_passes;

  datapath_struct_29 #(.W(W), .CW(CW)) dut (
    .clock  (clock),
    .reset  (reset),
    .state  (state),
    .din    (din),
    .E      (E),
    .F      (F),
    .A      (A),
    .R      (R),
    .C      (C),
    .done   (done),
    .passes (passes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".A"},      int'(A),      m_a);
    chk({tag, ".R"},      int'(R),      m_r);
    chk({tag, ".C"},      int'(C),      m_c);
    chk({tag, ".done"},   int'(done),   m_done);
    chk({tag, ".passes"}, int'(passes), m_passes);
    chk({tag, ".E"},      int'(E),      (m_a == 0) ? 1 : 0);
    chk({tag, ".F"},      int'(F),      (m_a > (MASK >> 1)) ? 1 : 0);
  endtask

  task automatic model_reset();
    m_a = 0; m_r = 0; m_c = 0; m_done = 0; m_passes = 0;
  endtask

  // What one clock edge does to the datapath, in plain arithmetic
  task automatic model_step(input int st, input int d);
    m_done = 0;
    case (st)
      1: begin m_a = d; m_c = 0; end
      2, 4: begin
        if (m_a == MASK) m_c = 1;
        m_a = (m_a + 1) % (MASK + 1);
      end
      3: m_a = m_a / 2;
      5, 7: begin
        m_r = m_a;
        m_done = 1;
        if (m_passes < PMAX) m_passes = m_passes + 1;
      end
      6: m_a = (m_a + MASK) % (MASK + 1);
      default: ;
    endcase
  endtask

  // Apply one state code for one clock, then check against the model
  task automatic step(input int st, input int d, input string tag);
    state = 3'(st);
    din   = W'(d);
    @(posedge clock);
    #1;
    model_step(st, d);
    chk_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk_all(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset = 1'b0;
    state = 3'd0;
    din   = '0;
    model_reset();
    #1;
    chk_all("reset_init");
    @(negedge clock);
    reset = 1'b1;

    // Async reset between edges
    step(1, 4'hA, "load_A");
    async_reset_pulse("async_rst");

    // Increment wrap and carry clear on load
    step(1, 4'hF, "load_F");
    step(2, 0, "inc_wrap");
    step(1, 4'h3, "load_3");

    // Shift and flags
    step(1, 4'b1001, "load_9");
    step(3, 0, "shr");
    step(4, 0, "inc_s4");

    // Decrement and result
    step(1, 0, "load_0");
    step(6, 0, "dec_wrap");
    step(7, 0, "latch_s7");
    step(0, 0, "hold_after_s7");

    // Controller-path replay
    step(0, 4'h6, "replay_s0");
    step(1, 4'h6, "replay_s1");
    step(2, 4'h6, "replay_s2");
    step(4, 4'h6, "replay_s4");
    step(5, 4'h6, "replay_s5");
    step(0, 4'h6, "replay_s0b");

    // Saturation of the pass counter
    for (int i = 0; i < 300; i++) begin
      step(5, 0, "sat_s5");
    end
    step(0, 0, "sat_end");

    // Random sequences with occasional mid-cycle reset
    for (int i = 0; i < 3000; i++) begin
      step(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)), "rand");
      if ($urandom_range(0, 99) == 0) begin
        async_reset_pulse("rand_rst");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
